alu_exec: RTL



---
 rtl/turtle_pkg.sv | 35 +++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/alu_exec.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/turtle_pkg.sv
// Shared TurtleMCU datapath definitions: opcodes, data width, execute FSM
// states and the register-file write-back predicate.
package turtle_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned OPW   = 4;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_MUL = 4'd7,
      OP_ADC = 4'd8,
      OP_CMP = 4'd9,
      OP_MOV = 4'd10,
      OP_NOP = 4'd11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // CMP only updates flags and NOP does nothing; every other op writes back.
   function automatic logic writes_rf(op_t op);
      return !(op == OP_CMP || op == OP_NOP);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per iteration.
// The load cycle performs the first iteration, so WIDTH iterations finish
// after load plus WIDTH-1 steps.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : capture operands and run iteration 1
//   step_i     : run the next iteration
//   a_i, b_i   : multiplicand / multiplier
//   prod_o     : full 2*WIDTH product (valid when done_o)
//   done_o     : all iterations complete
module alu_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               done_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // One iteration: add multiplicand into the upper half if the current
   // multiplier LSB is set, then shift the whole accumulator right.
   function automatic logic [2*WIDTH-1:0] iter(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] s;
      s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {s, p[WIDTH-1:1]};
   endfunction

   // Next-state for operand, accumulator and iteration count.
   always_comb begin
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         mcand_d = a_i;
         prod_d  = iter({{WIDTH{1'b0}}, b_i}, a_i);
         cnt_d   = CNT_W'(1);
      end else if (step_i) begin
         prod_d  = iter(prod_q, mcand_q);
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   assign prod_o = prod_q;
   assign done_o = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/alu_exec.sv
// TurtleMCU execute stage: single-cycle ALU ops, iterative shifts and
// multiply under a start/busy/done handshake, plus Z/C/N status flags.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, op, a, b   : op request; accepted in IDLE or FIN
//   busy              : multi-cycle op in flight (SHIFT/MUL)
//   done              : one-cycle pulse, result/flags valid
//   result, wb_en     : register-file write data and strobe
//   flag_z/c/n        : status flags
module alu_exec
   import turtle_pkg::*;
#(
   parameter int unsigned WIDTH = turtle_pkg::WIDTH,
   parameter int unsigned OPW   = turtle_pkg::OPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             wb_en,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n
);

   state_t           state_q;
   logic             busy_q, done_q, wb_en_q;
   logic [WIDTH-1:0] result_q;
   logic             flag_z_q, flag_c_q, flag_n_q;
   logic [WIDTH-1:0] sh_q;
   logic [2:0]       sh_cnt_q;
   logic             sh_dir_q;

   op_t              op_c;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic [WIDTH:0]   ext;
   logic [WIDTH:0]   a_x, b_x;
   logic             is_mul, is_shift, accept;
   logic [WIDTH-1:0] sh_nxt;
   logic             sh_out;
   logic             mul_load, mul_step, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   // Opcodes 11..15 all behave as NOP.
   always_comb begin
      op_c = OP_NOP;
      if (4'(op) <= 4'(OP_MOV)) op_c = op_t'(4'(op));
   end

   // Single-cycle datapath; shifts by zero pass a through.
   always_comb begin
      a_x   = {1'b0, a};
      b_x   = {1'b0, b};
      ext   = '0;
      res_d = result_q;
      c_d   = flag_c_q;
      case (op_c)
         OP_ADD: begin
            ext   = a_x + b_x;
            res_d = ext[WIDTH-1:0];
            c_d   = ext[WIDTH];
         end
         OP_SUB, OP_CMP: begin
            ext   = a_x - b_x;
            res_d = ext[WIDTH-1:0];
            c_d   = ext[WIDTH];
         end
         OP_ADC: begin
            ext   = a_x + b_x + {{WIDTH{1'b0}}, flag_c_q};
            res_d = ext[WIDTH-1:0];
            c_d   = ext[WIDTH];
         end
         OP_AND:         res_d = a & b;
         OP_OR:          res_d = a | b;
         OP_XOR:         res_d = a ^ b;
         OP_SHL, OP_SHR: res_d = a;
         OP_MOV:         res_d = b;
         default:        ;
      endcase
   end

   assign is_mul   = (op_c == OP_MUL);
   assign is_shift = (op_c == OP_SHL || op_c == OP_SHR) && (b[2:0] != 3'd0);
   assign accept   = start && (state_q == ST_IDLE || state_q == ST_FIN);

   // One-bit shift step; sh_out is the bit leaving the register.
   assign sh_nxt = sh_dir_q ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
   assign sh_out = sh_dir_q ? sh_q[0] : sh_q[WIDTH-1];

   assign mul_load = accept && is_mul;
   assign mul_step = (state_q == ST_MUL) && !mul_done;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (mul_load),
      .step_i (mul_step),
      .a_i    (a),
      .b_i    (b),
      .prod_o (mul_prod),
      .done_o (mul_done)
   );

   // Execute FSM with registered handshake, result and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wb_en_q  <= 1'b0;
         result_q <= '0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_n_q <= 1'b0;
         sh_q     <= '0;
         sh_cnt_q <= '0;
         sh_dir_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         wb_en_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_FIN: begin
               state_q <= ST_IDLE;
               if (start) begin
                  if (is_mul) begin
                     busy_q  <= 1'b1;
                     state_q <= ST_MUL;
                  end else if (is_shift) begin
                     sh_q     <= a;
                     sh_cnt_q <= b[2:0];
                     sh_dir_q <= (op_c == OP_SHR);
                     busy_q   <= 1'b1;
                     state_q  <= ST_SHIFT;
                  end else begin
                     state_q <= ST_FIN;
                     done_q  <= 1'b1;
                     wb_en_q <= writes_rf(op_c);
                     if (op_c != OP_NOP) begin
                        if (op_c != OP_CMP) result_q <= res_d;
                        flag_z_q <= (res_d == '0);
                        flag_n_q <= res_d[WIDTH-1];
                        flag_c_q <= c_d;
                     end
                  end
               end
            end
            ST_SHIFT: begin
               if (sh_cnt_q == 3'd1) begin
                  result_q <= sh_nxt;
                  flag_z_q <= (sh_nxt == '0);
                  flag_n_q <= sh_nxt[WIDTH-1];
                  flag_c_q <= sh_out;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  wb_en_q  <= 1'b1;
                  state_q  <= ST_FIN;
               end else begin
                  sh_q     <= sh_nxt;
                  sh_cnt_q <= sh_cnt_q - 3'd1;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  result_q <= mul_prod[WIDTH-1:0];
                  flag_z_q <= (mul_prod[WIDTH-1:0] == '0);
                  flag_n_q <= mul_prod[WIDTH-1];
                  flag_c_q <= |mul_prod[2*WIDTH-1:WIDTH];
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  wb_en_q  <= 1'b1;
                  state_q  <= ST_FIN;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign wb_en  = wb_en_q;
   assign result = result_q;
   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
   assign flag_n = flag_n_q;

endmodule
